// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out word receiver.
// Assembles WIDTH framed serial bits into a word and holds it on a
// valid/ready output register; flags overrun when a completed word
// arrives while the previous one is still unconsumed.
//
// state | meaning
// IDLE  | no frame in progress, waiting for BitValid & FrameStart
// SHIFT | frame partially received, count_q bits collected so far
module serial_word_receiver #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SerialInput,
    input  logic             BitValid,
    input  logic             FrameStart,
    input  logic             DataReady,
    input  logic             ClearOverrun,
    output logic [WIDTH-1:0] ParallelOutput,
    output logic             DataValid,
    output logic             Overrun,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             dv_q, dv_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // Shift register contents after taking in the current bit; a frame
    // start shifts into a cleared register so aborted bits never leak.
    always_comb begin
        shift_base = FrameStart ? '0 : sr_q;
        if (LSB_FIRST) begin
            shifted = {SerialInput, shift_base[WIDTH-1:1]};
        end else begin
            shifted = {shift_base[WIDTH-2:0], SerialInput};
        end
    end

    // Frame sequencing: next state, bit counter, shift register, completion.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sr_d     = sr_q;
        complete = 1'b0;
        if (BitValid) begin
            case (state_q)
                IDLE: begin
                    if (FrameStart) begin
                        sr_d    = shifted;
                        count_d = CW'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (FrameStart) begin
                        sr_d    = shifted;
                        count_d = CW'(1);
                    end else if (count_q == CW'(WIDTH - 1)) begin
                        // Last bit: word goes straight to the output stage.
                        complete = 1'b1;
                        count_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        sr_d    = shifted;
                        count_d = count_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Output stage: load/hold word, handshake, sticky overrun (set beats clear).
    always_comb begin
        po_d = po_q;
        dv_d = dv_q;
        ov_d = ov_q;
        if (ClearOverrun) begin
            ov_d = 1'b0;
        end
        if (complete) begin
            if (!dv_q || DataReady) begin
                po_d = shifted;
                dv_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (dv_q && DataReady) begin
            dv_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            sr_q    <= '0;
            po_q    <= '0;
            dv_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sr_q    <= sr_d;
            po_q    <= po_d;
            dv_q    <= dv_d;
            ov_q    <= ov_d;
        end
    end

    assign ParallelOutput = po_q;
    assign DataValid      = dv_q;
    assign Overrun        = ov_q;
    assign Busy           = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: one LSB-first and one
// MSB-first instance share the same serial stream.
module tb_serial_word_receiver;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       bv;
    logic       fs;
    logic       rdy;
    logic       clr;
    logic [7:0] po_l, po_m;
    logic       dv_l, dv_m, ov_l, ov_m, busy_l, busy_m;

    int n_checks = 0;
    int n_fail   = 0;

    serial_word_receiver #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .SerialInput(sin), .BitValid(bv),
        .FrameStart(fs), .DataReady(rdy), .ClearOverrun(clr),
        .ParallelOutput(po_l), .DataValid(dv_l), .Overrun(ov_l), .Busy(busy_l)
    );

    serial_word_receiver #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .SerialInput(sin), .BitValid(bv),
        .FrameStart(fs), .DataReady(rdy), .ClearOverrun(clr),
        .ParallelOutput(po_m), .DataValid(dv_m), .Overrun(ov_m), .Busy(busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One qualified bit, sampled on the next rising edge; returns 1 ns after it.
    task automatic send_bit(input logic b, input logic first);
        sin = b;
        bv  = 1'b1;
        fs  = first;
        @(posedge clk);
        #1;
        bv = 1'b0;
        fs = 1'b0;
    endtask

    // Bit i of w is the i-th bit sent.
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i], i == 0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] w;

    initial begin
        rst_n = 1'b0; sin = 1'b0; bv = 1'b0; fs = 1'b0; rdy = 1'b0; clr = 1'b0;
        #12;
        check("rst_po",   32'(po_l),   32'h0);
        check("rst_dv",   32'(dv_l),   32'h0);
        check("rst_ov",   32'(ov_l),   32'h0);
        check("rst_busy", 32'(busy_l), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

        // Basic receive: sequence 1,0,0,1,0,0,0,1
        w = 8'h89;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], i == 0);
            if (i == 6) begin
                check("basic_busy_mid", 32'(busy_l), 32'h1);
                check("basic_dv_mid",   32'(dv_l),   32'h0);
            end
        end
        check("basic_dv",    32'(dv_l),   32'h1);
        check("basic_po",    32'(po_l),   32'h89);
        check("basic_busy",  32'(busy_l), 32'h0);
        check("basic_po_msb", 32'(po_m),  32'h91);
        rdy = 1'b1;
        idle_cycle();
        rdy = 1'b0;
        check("basic_consume_dv", 32'(dv_l), 32'h0);
        check("basic_keep_po",    32'(po_l), 32'h89);
        idle_cycle();
        check("basic_dv_nochange", 32'(dv_l), 32'h0);

        // MSB-first with a 3-cycle gap between bits 4 and 5
        for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
        for (int g = 0; g < 3; g++) begin
            idle_cycle();
            check("gap_busy", 32'(busy_m), 32'h1);
        end
        for (int i = 4; i < 8; i++) send_bit(w[i], 1'b0);
        check("gap_po_msb", 32'(po_m),   32'h91);
        check("gap_dv_msb", 32'(dv_m),   32'h1);
        check("gap_busy_end", 32'(busy_m), 32'h0);
        check("gap_po_lsb", 32'(po_l),   32'h89);
        rdy = 1'b1; idle_cycle(); rdy = 1'b0;

        // Restart: 5 bits of a partial frame, then a full 0x3C frame
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        check("restart_busy", 32'(busy_l), 32'h1);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], i == 0);
            check("restart_dv", 32'(dv_l), 32'(i == 7));
        end
        check("restart_po", 32'(po_l), 32'h3C);
        check("restart_ov", 32'(ov_l), 32'h0);
        rdy = 1'b1; idle_cycle(); rdy = 1'b0;

        // Overrun with consumer stalled
        send_word(8'h89);
        send_word(8'h55);
        check("ovr_po", 32'(po_l), 32'h89);
        check("ovr_ov", 32'(ov_l), 32'h1);
        check("ovr_dv", 32'(dv_l), 32'h1);
        clr = 1'b1; idle_cycle(); clr = 1'b0;
        check("ovr_clear", 32'(ov_l), 32'h0);
        check("ovr_hold_po", 32'(po_l), 32'h89);
        // Set and clear on the same edge: set wins
        clr = 1'b1;
        send_word(8'h12);
        clr = 1'b0;
        check("ovr_set_wins", 32'(ov_l), 32'h1);
        check("ovr_po2", 32'(po_l), 32'h89);
        rdy = 1'b1; clr = 1'b1; idle_cycle(); rdy = 1'b0; clr = 1'b0;
        check("ovr_consume_dv", 32'(dv_l), 32'h0);
        check("ovr_consume_ov", 32'(ov_l), 32'h0);

        // Back-to-back with DataReady held high
        rdy = 1'b1;
        send_word(8'hA5);
        check("b2b_dv1", 32'(dv_l), 32'h1);
        check("b2b_po1", 32'(po_l), 32'hA5);
        send_word(8'h5A);
        check("b2b_dv2", 32'(dv_l), 32'h1);
        check("b2b_po2", 32'(po_l), 32'h5A);
        check("b2b_ov",  32'(ov_l), 32'h0);
        // Held word replaced directly by a transfer on the completion edge
        rdy = 1'b0;
        w = 8'hC3;
        for (int i = 0; i < 7; i++) send_bit(w[i], i == 0);
        check("b2b_hold_po", 32'(po_l), 32'h5A);
        check("b2b_hold_dv", 32'(dv_l), 32'h1);
        rdy = 1'b1;
        send_bit(w[7], 1'b0);
        check("b2b_swap_po", 32'(po_l), 32'hC3);
        check("b2b_swap_dv", 32'(dv_l), 32'h1);
        check("b2b_swap_ov", 32'(ov_l), 32'h0);
        idle_cycle();
        rdy = 1'b0;
        check("b2b_drain_dv", 32'(dv_l), 32'h0);

        // Asynchronous reset mid-frame with a held word and overrun set
        send_word(8'h33);
        send_word(8'h44);
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
        check("arst_pre_ov",   32'(ov_l),   32'h1);
        check("arst_pre_busy", 32'(busy_l), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_po",   32'(po_l),   32'h0);
        check("arst_dv",   32'(dv_l),   32'h0);
        check("arst_ov",   32'(ov_l),   32'h0);
        check("arst_busy", 32'(busy_l), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h0F);
        check("post_po", 32'(po_l), 32'h0F);
        check("post_dv", 32'(dv_l), 32'h1);
        check("post_ov", 32'(ov_l), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
